demux_1xn_stream: RTL and testbench

Parametrised, registered 1-to-N demultiplexer with valid/ready flow control on the input and on every output channel. Each input word is steered by `sel` into a one-entry output register for the chosen channel, with per-channel backpressure and a sticky error flag for out-of-range selects. It succeeds the combinational 1x8 demux where data must cross into independently stalling consumers.

---
 rtl/demux_1xn_stream.sv | 176 +++++++++++++++++
 tb/tb_demux_1xn_stream.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/demux_1xn_stream.sv
// ---------------------------------------------------------------------------
// demux_1xn_stream
//
// Registered 1-to-CH stream demultiplexer. Each accepted input word is steered
// by `sel` into a one-entry holding register owned by the addressed channel.
// Every channel has its own valid/ready handshake, so a stalled consumer only
// blocks words addressed to that same channel. Words whose `sel` names a
// channel that does not exist (possible only when CH is not a power of two)
// are accepted, discarded, and flagged through the sticky `sel_err`.
//
// Optional feature macro: DEMUX_DROP_CNT_EN
//   When defined, adds the `drop_cnt` output: a saturating 16-bit count of
//   discarded out-of-range words, cleared by rst.
//
// Parameters
//   WIDTH   data word width
//   CH      number of output channels (2..64)
//   SEL_W   width of sel, derived as $clog2(CH)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   din        input word
//   sel        destination channel of din
//   din_valid  din/sel valid
//   din_ready  input accepted this cycle (combinational from sel, y_ready,
//              channel state; never from din_valid)
//   y          channel k data at y[k*WIDTH +: WIDTH]
//   y_valid    channel k holds a word
//   y_ready    channel k consumer takes its word
//   drop_cnt   discarded-word count (DEMUX_DROP_CNT_EN only)
//   sel_err    sticky out-of-range select flag
// ---------------------------------------------------------------------------
module demux_1xn_stream #(
    parameter  int WIDTH = 8,
    parameter  int CH    = 8,
    localparam int SEL_W = $clog2(CH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDTH-1:0]    din,
    input  logic [SEL_W-1:0]    sel,
    input  logic                din_valid,
    output logic                din_ready,
    output logic [CH*WIDTH-1:0] y,
    output logic [CH-1:0]       y_valid,
    input  logic [CH-1:0]       y_ready,
`ifdef DEMUX_DROP_CNT_EN
    output logic [15:0]         drop_cnt,
`endif
    output logic                sel_err
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ch_state_t;

    ch_state_t        state_p0  [CH];
    ch_state_t        state_nxt [CH];
    logic [WIDTH-1:0] data_p0   [CH];
    logic [CH-1:0]    vld_p0;
    logic [CH-1:0]    load;
    logic             in_range;
    logic             ready_sel;
    logic             acc;

`ifdef DEMUX_DROP_CNT_EN
    logic [15:0]      drop_p0;

    // Saturating increment: the count sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end
        return v + 16'd1;
    endfunction
`endif

    // Decode sel against the channels that actually exist. A select with no
    // matching channel leaves in_range low and the input always ready, so an
    // out-of-range word is swallowed in a single cycle.
    always_comb begin
        in_range  = 1'b0;
        ready_sel = 1'b1;
        for (int k = 0; k < CH; k++) begin
            if (sel == SEL_W'(k)) begin
                in_range  = 1'b1;
                ready_sel = ~vld_p0[k] | y_ready[k];
            end
        end
    end

    assign din_ready = ready_sel;
    assign acc       = din_valid & ready_sel;

    always_comb begin
        load = '0;
        for (int k = 0; k < CH; k++) begin
            load[k] = acc & in_range & (sel == SEL_W'(k));
        end
    end

    // Per-channel EMPTY/FULL control. A load into a FULL channel only happens
    // when its consumer is taking the current word, so it stays FULL with the
    // new word: one word per clock into a single channel.
    always_comb begin
        for (int k = 0; k < CH; k++) begin
            state_nxt[k] = state_p0[k];
            vld_p0[k]    = (state_p0[k] == FULL);
            case (state_p0[k])
                EMPTY: begin
                    if (load[k]) begin
                        state_nxt[k] = FULL;
                    end
                end
                FULL: begin
                    if (load[k]) begin
                        state_nxt[k] = FULL;
                    end else if (y_ready[k]) begin
                        state_nxt[k] = EMPTY;
                    end
                end
                default: state_nxt[k] = EMPTY;
            endcase
        end
    end

    // ---- stage p0: channel holding registers ----
    // Data only changes on a load; it keeps the last word after a drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < CH; k++) begin
                state_p0[k] <= EMPTY;
                data_p0[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < CH; k++) begin
                state_p0[k] <= state_nxt[k];
                if (load[k]) begin
                    data_p0[k] <= din;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_err <= 1'b0;
        end else if (acc & ~in_range) begin
            sel_err <= 1'b1;
        end
    end

`ifdef DEMUX_DROP_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_p0 <= '0;
        end else if (acc & ~in_range) begin
            drop_p0 <= sat_inc16(drop_p0);
        end
    end

    assign drop_cnt = drop_p0;
`endif

    always_comb begin
        y = '0;
        for (int k = 0; k < CH; k++) begin
            y[k*WIDTH +: WIDTH] = data_p0[k];
        end
    end

    assign y_valid = vld_p0;

endmodule

// File: tb/tb_demux_1xn_stream.sv
`timescale 1ns/100ps
module tb_demux_1xn_stream;

    localparam int WIDTH = 8;
    localparam int CH    = 6;
    localparam int SEL_W = 3;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [WIDTH-1:0]    din = '0;
    logic [SEL_W-1:0]    sel = '0;
    logic                din_valid = 1'b0;
    logic                din_ready;
    logic [CH*WIDTH-1:0] y;
    logic [CH-1:0]       y_valid;
    logic [CH-1:0]       y_ready = '0;
    logic                sel_err;
`ifdef DEMUX_DROP_CNT_EN
    logic [15:0]         drop_cnt;
    logic [15:0]         m_drop = '0;
`endif

    demux_1xn_stream #(.WIDTH(WIDTH), .CH(CH)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .sel       (sel),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .y         (y),
        .y_valid   (y_valid),
        .y_ready   (y_ready),
`ifdef DEMUX_DROP_CNT_EN
        .drop_cnt  (drop_cnt),
`endif
        .sel_err   (sel_err)
    );

    always #5 clk = ~clk;

    // Reference model: one FIFO of words owed to each channel's consumer.
    typedef logic [WIDTH-1:0] word_q_t[$];
    word_q_t q [CH];
    logic    m_err = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic model_ready(input logic [SEL_W-1:0] s);
        if (int'(s) >= CH) return 1'b1;
        return (q[s].size() == 0) || y_ready[s];
    endfunction

    task automatic model_clear();
        for (int k = 0; k < CH; k++) q[k].delete();
        m_err = 1'b0;
`ifdef DEMUX_DROP_CNT_EN
        m_drop = '0;
`endif
    endtask

    // Monitor: 3 ns after each falling edge, compare outputs with the model and
    // retire words the consumer is taking at the coming rising edge.
    always @(negedge clk) begin
        #3;
        if (!rst) begin
            check("din_ready", 64'(din_ready), 64'(model_ready(sel)));
            check("sel_err", 64'(sel_err), 64'(m_err));
`ifdef DEMUX_DROP_CNT_EN
            check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
`endif
            for (int k = 0; k < CH; k++) begin
                check($sformatf("y_valid[%0d]", k), 64'(y_valid[k]), 64'(q[k].size() != 0));
                if (q[k].size() != 0) begin
                    check($sformatf("y[%0d]", k), 64'(y[k*WIDTH +: WIDTH]), 64'(q[k][0]));
                    if (y_ready[k]) void'(q[k].pop_front());
                end
            end
        end
    end

    // Driver: apply inputs at the falling edge; the word is owed to its channel
    // if the model says the block can take it.
    task automatic cycle(input logic v, input logic [SEL_W-1:0] s, input logic [WIDTH-1:0] d,
                         input logic [CH-1:0] yr, output logic rdy);
        logic acc_m;
        @(negedge clk);
        din_valid = v; sel = s; din = d; y_ready = yr;
        #2;
        rdy   = din_ready;
        acc_m = v && model_ready(s);
        #2;
        if (acc_m) begin
            if (int'(s) < CH) q[s].push_back(d);
            else begin
                m_err = 1'b1;
`ifdef DEMUX_DROP_CNT_EN
                if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
`endif
            end
        end
    endtask

    logic           r;
    logic [CH-1:0]  ones = '1;
    logic [CH-1:0]  bp;

    initial begin
        // Reset state
        #2;
        check("rst_y_valid", 64'(y_valid), 64'd0);
        check("rst_y", 64'(y), 64'd0);
        check("rst_sel_err", 64'(sel_err), 64'd0);
        check("rst_din_ready", 64'(din_ready), 64'd1);
`ifdef DEMUX_DROP_CNT_EN
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;

        // Single pass into every channel
        for (int k = 0; k < CH; k++) begin
            cycle(1'b1, SEL_W'(k), 8'hA0 + 8'(k), ones, r);
            check("pass_ready", 64'(r), 64'd1);
        end
        cycle(1'b0, '0, '0, ones, r);
        cycle(1'b0, '0, '0, ones, r);
        check("drained_valid", 64'(y_valid), 64'd0);
        for (int k = 0; k < CH; k++)
            check("data_kept_after_drain", 64'(y[k*WIDTH +: WIDTH]), 64'(8'hA0 + 8'(k)));

        // Backpressure on channel 3, with channel 5 flowing past the stall
        bp = ones; bp[3] = 1'b0;
        cycle(1'b1, 3'd3, 8'h11, bp, r);
        check("bp_first_ready", 64'(r), 64'd1);
        cycle(1'b1, 3'd3, 8'h22, bp, r);
        check("bp_second_ready", 64'(r), 64'd0);
        check("bp_hold_y3", 64'(y[3*WIDTH +: WIDTH]), 64'h11);
        cycle(1'b1, 3'd5, 8'h55, bp, r);
        check("indep_ready", 64'(r), 64'd1);
        cycle(1'b1, 3'd3, 8'h22, bp, r);
        check("indep_y5", 64'(y[5*WIDTH +: WIDTH]), 64'h55);
        check("indep_v5", 64'(y_valid[5]), 64'd1);
        check("bp_stable_y3", 64'(y[3*WIDTH +: WIDTH]), 64'h11);
        cycle(1'b1, 3'd3, 8'h22, ones, r);
        check("bp_release_ready", 64'(r), 64'd1);
        cycle(1'b0, '0, '0, ones, r);
        check("bp_second_y3", 64'(y[3*WIDTH +: WIDTH]), 64'h22);
        check("bp_second_v3", 64'(y_valid[3]), 64'd1);
        cycle(1'b0, '0, '0, ones, r);

        // Out-of-range select
        cycle(1'b1, 3'd7, 8'hFF, ones, r);
        check("oor_ready", 64'(r), 64'd1);
        cycle(1'b0, '0, '0, ones, r);
        check("oor_sel_err", 64'(sel_err), 64'd1);
        check("oor_no_valid", 64'(y_valid), 64'd0);
`ifdef DEMUX_DROP_CNT_EN
        check("oor_drop_1", 64'(drop_cnt), 64'd1);
`endif
        cycle(1'b1, 3'd6, 8'hFF, ones, r);
        cycle(1'b1, 3'd7, 8'hFF, ones, r);
        cycle(1'b1, 3'd6, 8'hFF, ones, r);
        cycle(1'b0, '0, '0, ones, r);
        check("oor_sel_err_sticky", 64'(sel_err), 64'd1);
`ifdef DEMUX_DROP_CNT_EN
        check("oor_drop_4", 64'(drop_cnt), 64'd4);
`endif

        // Asynchronous reset with channels 0, 2, 5 full
        cycle(1'b1, 3'd0, 8'h10, '0, r);
        cycle(1'b1, 3'd2, 8'h12, '0, r);
        cycle(1'b1, 3'd5, 8'h15, '0, r);
        cycle(1'b0, '0, '0, '0, r);
        check("pre_rst_valid", 64'(y_valid), 64'b100101);
        @(negedge clk);
        din_valid = 1'b0;
        #1 rst = 1'b1;
        #0.5;
        check("arst_y_valid", 64'(y_valid), 64'd0);
        check("arst_y", 64'(y), 64'd0);
        check("arst_sel_err", 64'(sel_err), 64'd0);
        check("arst_din_ready", 64'(din_ready), 64'd1);
`ifdef DEMUX_DROP_CNT_EN
        check("arst_drop_cnt", 64'(drop_cnt), 64'd0);
`endif
        model_clear();
        #0.5 rst = 1'b0;

        // Randomized traffic against the scoreboard
        for (int i = 0; i < 1000; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), SEL_W'($urandom_range(0, 7)),
                  WIDTH'($urandom), CH'($urandom), r);
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, '0, ones, r);
        check("final_empty", 64'(y_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
